// File: rtl/iddr_align_ctrl.sv
// ---------------------------------------------------------------------------
// iddr_align_ctrl
//
// Per-lane IDELAY tap training for a bank of IDDR inputs carrying a static
// training pattern. Lanes are trained one after another (0..WIDTH-1):
//   * every IDELAY tap is loaded, allowed to settle, then the registered
//     q1/q2 samples of the lane are compared for COMPARE_CYC cycles;
//   * the tap is centred in the widest run of passing taps (earliest wins
//     on ties);
//   * if no run of at least MIN_WIN taps exists with the normal q1/q2
//     orientation, the sweep is repeated with q1/q2 swapped (half-cycle
//     slip). If that also fails the lane is parked at the mid tap and the
//     sticky error flag is raised.
//
// Ports
//   clk       capture clock (same clock as the IDDR q outputs)
//   rst_n     asynchronous active-low reset
//   start     pulse: train all lanes (ignored while busy)
//   q1, q2    IDDR rising/falling-edge outputs, bit n = lane n
//   dly_lane  lane addressed by dly_load
//   dly_tap   tap value to load
//   dly_load  one-cycle load strobe for the IDELAY of dly_lane
//   swap      per lane: downstream must swap q1/q2
//   locked    per lane: training found a usable window
//   busy      training in progress
//   done      all lanes processed; held until the next start
//   err       sticky: at least one lane failed both orientations
// ---------------------------------------------------------------------------
module iddr_align_ctrl #(
  parameter int                WIDTH       = 4,
  parameter int                TAP_BITS    = 5,
  parameter int                SETTLE_CYC  = 8,
  parameter int                COMPARE_CYC = 16,
  parameter int                MIN_WIN     = 4,
  parameter logic [WIDTH-1:0]  EXP_Q1      = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]  EXP_Q2      = {WIDTH{1'b0}},
  localparam int               LB          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    q1,
  input  logic [WIDTH-1:0]    q2,
  output logic [LB-1:0]       dly_lane,
  output logic [TAP_BITS-1:0] dly_tap,
  output logic                dly_load,
  output logic [WIDTH-1:0]    swap,
  output logic [WIDTH-1:0]    locked,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // Run lengths need one extra bit so a window covering every tap fits.
  localparam int RB   = TAP_BITS + 1;
  localparam int CMAX = (SETTLE_CYC > COMPARE_CYC) ? SETTLE_CYC : COMPARE_CYC;
  localparam int CB   = $clog2(CMAX) + 1;

  localparam logic [TAP_BITS-1:0] LAST_TAP = {TAP_BITS{1'b1}};
  localparam logic [TAP_BITS-1:0] MID_TAP  = TAP_BITS'(1) << (TAP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CHECK     = 3'd3,
    ST_EVAL      = 3'd4,
    ST_CENTER    = 3'd5,
    ST_NEXT_LANE = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  // Registered state
  state_t              state_r, state_n;
  logic [LB-1:0]       lane_r, lane_n;
  logic [TAP_BITS-1:0] tap_r, tap_n;
  logic                orient_r, orient_n;
  logic [CB-1:0]       cnt_r, cnt_n;
  logic                tap_ok_r, tap_ok_n;
  logic [TAP_BITS-1:0] cur_start_r, cur_start_n;
  logic [RB-1:0]       cur_len_r, cur_len_n;
  logic [TAP_BITS-1:0] best_start_r, best_start_n;
  logic [RB-1:0]       best_len_r, best_len_n;
  logic [WIDTH-1:0]    q1_r, q2_r;

  // Registered outputs
  logic [LB-1:0]       dly_lane_r, dly_lane_n;
  logic [TAP_BITS-1:0] dly_tap_r, dly_tap_n;
  logic                dly_load_r, dly_load_n;
  logic [WIDTH-1:0]    swap_r, swap_n;
  logic [WIDTH-1:0]    locked_r, locked_n;
  logic                busy_r, busy_n;
  logic                done_r, done_n;
  logic                err_r, err_n;

  // Combinational helpers
  logic                sample_ok_s;
  logic [TAP_BITS-1:0] run_start_s;
  logic [RB-1:0]       run_len_s;
  logic                last_tap_s;
  logic                close_run_s;
  logic [TAP_BITS-1:0] center_tap_s;

  // Compare the current lane's registered sample against the expected pattern.
  always_comb begin
    sample_ok_s = 1'b0;
    if (orient_r == 1'b0) begin
      sample_ok_s = (q1_r[lane_r] == EXP_Q1[lane_r]) && (q2_r[lane_r] == EXP_Q2[lane_r]);
    end else begin
      sample_ok_s = (q1_r[lane_r] == EXP_Q2[lane_r]) && (q2_r[lane_r] == EXP_Q1[lane_r]);
    end
  end

  // Open run including the tap just scored; a failing tap leaves it unchanged.
  always_comb begin
    run_start_s = cur_start_r;
    run_len_s   = cur_len_r;
    if (tap_ok_r) begin
      run_start_s = (cur_len_r == {RB{1'b0}}) ? tap_r : cur_start_r;
      run_len_s   = cur_len_r + RB'(1);
    end else begin
      run_start_s = cur_start_r;
      run_len_s   = cur_len_r;
    end
  end

  // The run closes on a failing tap or at the end of the sweep.
  always_comb begin
    last_tap_s   = (tap_r == LAST_TAP);
    close_run_s  = (~tap_ok_r) | last_tap_s;
    center_tap_s = best_start_r + TAP_BITS'((best_len_r - RB'(1)) >> 1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state_r;
    lane_n       = lane_r;
    tap_n        = tap_r;
    orient_n     = orient_r;
    cnt_n        = cnt_r;
    tap_ok_n     = tap_ok_r;
    cur_start_n  = cur_start_r;
    cur_len_n    = cur_len_r;
    best_start_n = best_start_r;
    best_len_n   = best_len_r;
    dly_lane_n   = dly_lane_r;
    dly_tap_n    = dly_tap_r;
    dly_load_n   = 1'b0;
    swap_n       = swap_r;
    locked_n     = locked_r;
    busy_n       = busy_r;
    done_n       = done_r;
    err_n        = err_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lane_n       = {LB{1'b0}};
          tap_n        = {TAP_BITS{1'b0}};
          orient_n     = 1'b0;
          cnt_n        = {CB{1'b0}};
          cur_start_n  = {TAP_BITS{1'b0}};
          cur_len_n    = {RB{1'b0}};
          best_start_n = {TAP_BITS{1'b0}};
          best_len_n   = {RB{1'b0}};
          locked_n     = {WIDTH{1'b0}};
          swap_n       = {WIDTH{1'b0}};
          err_n        = 1'b0;
          done_n       = 1'b0;
          busy_n       = 1'b1;
          state_n      = ST_LOAD;
        end else begin
          state_n = state_r;
        end
      end

      ST_LOAD: begin
        dly_load_n = 1'b1;
        dly_lane_n = lane_r;
        dly_tap_n  = tap_r;
        cnt_n      = {CB{1'b0}};
        state_n    = ST_SETTLE;
      end

      ST_SETTLE: begin
        // The load strobe is registered and q is registered once more, so
        // the settle window also absorbs those two cycles of latency.
        if (cnt_r == CB'(SETTLE_CYC - 1)) begin
          cnt_n    = {CB{1'b0}};
          tap_ok_n = 1'b1;
          state_n  = ST_CHECK;
        end else begin
          cnt_n = cnt_r + CB'(1);
        end
      end

      ST_CHECK: begin
        if (!sample_ok_s) begin
          tap_ok_n = 1'b0;
        end else begin
          tap_ok_n = tap_ok_r;
        end
        if (cnt_r == CB'(COMPARE_CYC - 1)) begin
          cnt_n   = {CB{1'b0}};
          state_n = ST_EVAL;
        end else begin
          cnt_n = cnt_r + CB'(1);
        end
      end

      ST_EVAL: begin
        cur_start_n = run_start_s;
        // Strictly greater: on equal lengths the earlier window is kept.
        if (close_run_s && (run_len_s > best_len_r)) begin
          best_start_n = run_start_s;
          best_len_n   = run_len_s;
        end else begin
          best_start_n = best_start_r;
          best_len_n   = best_len_r;
        end
        if (close_run_s) begin
          cur_len_n = {RB{1'b0}};
        end else begin
          cur_len_n = run_len_s;
        end
        if (last_tap_s) begin
          state_n = ST_CENTER;
        end else begin
          tap_n   = tap_r + TAP_BITS'(1);
          state_n = ST_LOAD;
        end
      end

      ST_CENTER: begin
        if (best_len_r >= RB'(MIN_WIN)) begin
          tap_n            = center_tap_s;
          locked_n[lane_r] = 1'b1;
          swap_n[lane_r]   = orient_r;
          dly_load_n       = 1'b1;
          dly_lane_n       = lane_r;
          dly_tap_n        = center_tap_s;
          state_n          = ST_NEXT_LANE;
        end else if (orient_r == 1'b0) begin
          // No usable window: retry the whole sweep with q1/q2 swapped.
          orient_n     = 1'b1;
          tap_n        = {TAP_BITS{1'b0}};
          cur_start_n  = {TAP_BITS{1'b0}};
          cur_len_n    = {RB{1'b0}};
          best_start_n = {TAP_BITS{1'b0}};
          best_len_n   = {RB{1'b0}};
          state_n      = ST_LOAD;
        end else begin
          // Both orientations failed: park the lane at the mid tap.
          tap_n            = MID_TAP;
          locked_n[lane_r] = 1'b0;
          swap_n[lane_r]   = 1'b0;
          err_n            = 1'b1;
          dly_load_n       = 1'b1;
          dly_lane_n       = lane_r;
          dly_tap_n        = MID_TAP;
          state_n          = ST_NEXT_LANE;
        end
      end

      ST_NEXT_LANE: begin
        if (lane_r == LB'(WIDTH - 1)) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = ST_DONE;
        end else begin
          lane_n       = lane_r + LB'(1);
          orient_n     = 1'b0;
          tap_n        = {TAP_BITS{1'b0}};
          cur_start_n  = {TAP_BITS{1'b0}};
          cur_len_n    = {RB{1'b0}};
          best_start_n = {TAP_BITS{1'b0}};
          best_len_n   = {RB{1'b0}};
          state_n      = ST_LOAD;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      lane_r       <= {LB{1'b0}};
      tap_r        <= {TAP_BITS{1'b0}};
      orient_r     <= 1'b0;
      cnt_r        <= {CB{1'b0}};
      tap_ok_r     <= 1'b0;
      cur_start_r  <= {TAP_BITS{1'b0}};
      cur_len_r    <= {RB{1'b0}};
      best_start_r <= {TAP_BITS{1'b0}};
      best_len_r   <= {RB{1'b0}};
      q1_r         <= {WIDTH{1'b0}};
      q2_r         <= {WIDTH{1'b0}};
      dly_lane_r   <= {LB{1'b0}};
      dly_tap_r    <= {TAP_BITS{1'b0}};
      dly_load_r   <= 1'b0;
      swap_r       <= {WIDTH{1'b0}};
      locked_r     <= {WIDTH{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_n;
      lane_r       <= lane_n;
      tap_r        <= tap_n;
      orient_r     <= orient_n;
      cnt_r        <= cnt_n;
      tap_ok_r     <= tap_ok_n;
      cur_start_r  <= cur_start_n;
      cur_len_r    <= cur_len_n;
      best_start_r <= best_start_n;
      best_len_r   <= best_len_n;
      q1_r         <= q1;
      q2_r         <= q2;
      dly_lane_r   <= dly_lane_n;
      dly_tap_r    <= dly_tap_n;
      dly_load_r   <= dly_load_n;
      swap_r       <= swap_n;
      locked_r     <= locked_n;
      busy_r       <= busy_n;
      done_r       <= done_n;
      err_r        <= err_n;
    end
  end

  assign dly_lane = dly_lane_r;
  assign dly_tap  = dly_tap_r;
  assign dly_load = dly_load_r;
  assign swap     = swap_r;
  assign locked   = locked_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule
